// File: rtl/repair_sol_buffer.sv
// repair_sol_buffer: collects BIRA repair solutions during a test session and
// streams them to the fuse programmer over a valid/ready handshake once the
// session ends repairable.
// Optional feature macro: SOL_PARITY_EN adds an out_parity output. It carries
// even parity over out_data, and this parity is stored per entry at write time.
module repair_sol_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sol_valid,
    input  logic [15:0]   solution,
    input  logic          test_end,
    input  logic          repair,
    input  logic          early_term,
    output logic          out_valid,
    output logic [15:0]   out_data,
`ifdef SOL_PARITY_EN
    output logic          out_parity,
`endif
    input  logic          out_ready,
    output logic [AW:0]   sol_count,
    output logic          done,
    output logic          fail
);

`ifdef SOL_PARITY_EN
    localparam int EW = 17;
`else
    localparam int EW = 16;
`endif
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_DRAIN, S_DONE, S_FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_word, rd_word;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          full, wr_en, ovf_set, rd_en, sess_start;

    assign full       = (count == CNT_FULL);
    assign sess_start = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign wr_en      = (state == S_COLLECT) && sol_valid && !full;
    assign ovf_set    = (state == S_COLLECT) && sol_valid && full;
    assign rd_en      = out_valid && out_ready;

`ifdef SOL_PARITY_EN
    assign wr_word = {^solution, solution};
`else
    assign wr_word = solution;
`endif
    assign rd_word = mem[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; a word arriving with test_end is folded into the
    // overflow decision so it is "stored" before the transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (early_term)
                    state_nxt = S_FAIL;
                else if (test_end)
                    state_nxt = (repair && !ovf && !ovf_set) ? S_DRAIN : S_FAIL;
            end
            S_DRAIN: if (count == '0) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (sess_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (ovf_set) ovf <= 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
            // A failed session holds nothing deliverable
            if (state_nxt == S_FAIL && state != S_FAIL) count <= '0;
        end
    end

    // Solution storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    // Outputs decoded from state and occupancy; data forced to 0 when idle
    always_comb begin
        out_valid = (state == S_DRAIN) && (count != '0);
        out_data  = out_valid ? rd_word[15:0] : 16'h0000;
`ifdef SOL_PARITY_EN
        out_parity = out_valid ? rd_word[16] : 1'b0;
`endif
        sol_count = count;
        done      = (state == S_DONE);
        fail      = (state == S_FAIL);
    end

endmodule

// File: tb/tb_repair_sol_buffer.sv
// tb_repair_sol_buffer: directed vectors with hand-computed expectations for
// repair_sol_buffer (DEPTH=8).
module tb_repair_sol_buffer;

    logic        clk = 1'b0;
    logic        rst, start, sol_valid, test_end, repair, early_term, out_ready;
    logic [15:0] solution, out_data;
    logic        out_valid, done, fail;
    logic [3:0]  sol_count;
`ifdef SOL_PARITY_EN
    logic        out_parity;
`endif

    int n_chk = 0;
    int n_err = 0;

    repair_sol_buffer #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .sol_valid(sol_valid),
        .solution(solution), .test_end(test_end), .repair(repair),
        .early_term(early_term), .out_valid(out_valid), .out_data(out_data),
`ifdef SOL_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready(out_ready), .sol_count(sol_count), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        start = 0; sol_valid = 0; solution = 16'h0; test_end = 0;
        repair = 0; early_term = 0; out_ready = 0;
    endtask

    task automatic begin_session();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic push(input logic [15:0] w, input logic last);
        sol_valid = 1; solution = w; test_end = last; repair = last;
        tick();
        sol_valid = 0; test_end = 0; repair = 0;
    endtask

    logic [15:0] w1 [3] = '{16'h2005, 16'h340A, 16'h0C3F};
    logic [15:0] w4 [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    logic        rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          eidx [7] = '{0, 1, 1, 1, 2, 3, 3};

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0;
        clr_in();
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_count", sol_count, 0);
        rst = 1;
        tick();
        check("idle_done", done, 0);

        // Basic three-word session
        begin_session();
        push(w1[0], 0); push(w1[1], 0); push(w1[2], 1);
        check("t1_count", sol_count, 3);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", out_valid, 1);
            check("t1_data", out_data, w1[i]);
            tick();
        end
        check("t1_empty_valid", out_valid, 0);
        check("t1_not_done_yet", done, 0);
        tick();
        check("t1_done", done, 1);
        out_ready = 0;
        sol_valid = 1; solution = 16'hFFFF;
        tick();
        sol_valid = 0;
        check("done_ignores_sol", sol_count, 0);
        check("done_hold", done, 1);

        // Overflow: nine words into eight entries
        begin_session();
        for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i), 0);
        check("ovf_count", sol_count, 8);
        test_end = 1; repair = 1;
        tick();
        test_end = 0; repair = 0;
        check("ovf_fail", fail, 1);
        check("ovf_count0", sol_count, 0);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            check("ovf_no_valid", out_valid, 0);
            tick();
        end
        out_ready = 0;

        // Early termination overrides a repairable test_end
        begin_session();
        check("et_clear_fail", fail, 0);
        push(16'h0101, 0); push(16'h0202, 0);
        check("et_count", sol_count, 2);
        early_term = 1; test_end = 1; repair = 1;
        tick();
        clr_in();
        check("et_fail", fail, 1);
        check("et_count0", sol_count, 0);

        // Unrepairable session
        begin_session();
        sol_valid = 1; solution = 16'h0042; test_end = 1; repair = 0;
        tick();
        clr_in();
        check("norep_fail", fail, 1);

        // Zero-solution session reaches DONE one cycle after DRAIN
        begin_session();
        test_end = 1; repair = 1;
        tick();
        clr_in();
        check("zero_drain_done", done, 0);
        check("zero_drain_valid", out_valid, 0);
        tick();
        check("zero_done", done, 1);

        // Backpressure during drain
        begin_session();
        push(w4[0], 0); push(w4[1], 0); push(w4[2], 0); push(w4[3], 1);
        check("bp_count", sol_count, 4);
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy[i];
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, w4[eidx[i]]);
            tick();
        end
        out_ready = 0;
        check("bp_count0", sol_count, 0);
        tick();
        check("bp_done", done, 1);

        // Asynchronous reset mid-drain, then a clean session
        begin_session();
        push(16'hB001, 0); push(16'hB002, 1);
        check("mr_valid", out_valid, 1);
        check("mr_count", sol_count, 2);
        #2 rst = 0;
        #1;
        check("mr_rst_valid", out_valid, 0);
        check("mr_rst_count", sol_count, 0);
        check("mr_rst_data", out_data, 0);
        tick();
        rst = 1;
        tick();
        check("mr_idle_done", done, 0);
        begin_session();
        push(16'h1234, 1);
        check("mr2_count", sol_count, 1);
        out_ready = 1;
        check("mr2_data", out_data, 16'h1234);
        tick(); tick();
        out_ready = 0;
        check("mr2_done", done, 1);

`ifdef SOL_PARITY_EN
        begin_session();
        push(16'h0007, 0); push(16'h0003, 1);
        check("par_7", out_parity, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("par_3_data", out_data, 16'h0003);
        check("par_3", out_parity, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
